// File: rtl/dma_frame_packer_pkg.sv
// Shared types and CRC helper for the DMA frame packer.
// Frame layout: sync, length, payload, CRC-8 (poly 0x07).
package dma_frame_packer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    PAYLOAD,
    CRC,
    ABORT,
    DRAIN
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // MSB-first byte update, no reflection, no final XOR
  function automatic logic [7:0] crc8(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7])
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else
        c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/dma_frame_packer_if.sv
// Framed byte stream with valid/ready handshake.
// Master drives data and markers, slave drives ready.
interface dma_frame_packer_if;

  logic [7:0] o_frame_data;
  logic       o_frame_valid;
  logic       o_frame_sof;
  logic       o_frame_eof;
  logic       i_frame_ready;

  modport master (
    output o_frame_data,
    output o_frame_valid,
    output o_frame_sof,
    output o_frame_eof,
    input  i_frame_ready
  );

  modport slave (
    input  o_frame_data,
    input  o_frame_valid,
    input  o_frame_sof,
    input  o_frame_eof,
    output i_frame_ready
  );

endinterface

// File: rtl/dma_frame_packer_sync_byte_fifo.sv
// Single-clock first-word fall-through byte FIFO.
// Pointers carry an extra wrap bit to tell full from empty.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge CLK) begin
    if (do_push && !flush)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dma_frame_packer.sv
// Wraps one DMA read's byte stream into sync/len/payload/CRC frames.
// Overflow aborts the frame with an inverted CRC and drains the input.
module dma_frame_packer
  import dma_frame_packer_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      i_Read_Request,
  input  logic [5:0]                i_RCC_BUFFER_LENGTH,
  input  logic [7:0]                i_serialized_output,
  input  logic                      i_serialized_output_valid,
  dma_frame_packer_if.master        frm,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_overflow
);

  state_t     state;
  state_t     state_nx;

  logic [7:0] n_len;
  logic [7:0] crc;
  logic [7:0] in_cnt;
  logic [7:0] out_cnt;
  logic       ovf;
  logic       done_q;

  logic       start;
  logic       take;
  logic       push;
  logic       drop;
  logic       pop;
  logic       flush;
  logic       beat;

  logic [7:0] head;
  logic       fifo_full;
  logic       fifo_empty;

  assign start = i_Read_Request && (state == IDLE);
  assign beat  = frm.o_frame_valid && frm.i_frame_ready;

  assign take  = i_serialized_output_valid &&
                 (state != IDLE) && (in_cnt < n_len);
  assign push  = take && (state != DRAIN) && !fifo_full;
  assign drop  = take && (state != DRAIN) && fifo_full;

  assign pop   = (state == PAYLOAD) && !ovf && beat;
  assign flush = (state == ABORT);

  sync_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_data (i_serialized_output),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_Read_Request)
          state_nx = SYNC;
      end
      SYNC: begin
        if (beat)
          state_nx = LEN;
      end
      LEN: begin
        if (beat)
          state_nx = (n_len == 8'd0) ? CRC : PAYLOAD;
      end
      PAYLOAD: begin
        if (ovf)
          state_nx = ABORT;
        else if (beat && (out_cnt + 8'd1 == n_len))
          state_nx = CRC;
      end
      CRC: begin
        if (beat)
          state_nx = IDLE;
      end
      ABORT: begin
        if (beat)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (in_cnt == n_len)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A pending payload beat is withdrawn as soon as overflow is seen
  always_comb begin
    frm.o_frame_valid = 1'b0;
    frm.o_frame_data  = 8'h00;
    frm.o_frame_sof   = 1'b0;
    frm.o_frame_eof   = 1'b0;
    unique case (state)
      SYNC: begin
        frm.o_frame_valid = 1'b1;
        frm.o_frame_data  = SYNC_BYTE;
        frm.o_frame_sof   = 1'b1;
      end
      LEN: begin
        frm.o_frame_valid = 1'b1;
        frm.o_frame_data  = n_len;
      end
      PAYLOAD: begin
        frm.o_frame_valid = !ovf && !fifo_empty;
        frm.o_frame_data  = ovf ? 8'h00 : head;
      end
      CRC: begin
        frm.o_frame_valid = 1'b1;
        frm.o_frame_data  = crc;
        frm.o_frame_eof   = 1'b1;
      end
      ABORT: begin
        frm.o_frame_valid = 1'b1;
        frm.o_frame_data  = ~crc;
        frm.o_frame_eof   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      n_len   <= 8'd0;
      crc     <= 8'd0;
      in_cnt  <= 8'd0;
      out_cnt <= 8'd0;
      ovf     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == CRC) && beat;
      if (start) begin
        n_len   <= {i_RCC_BUFFER_LENGTH, 2'b00};
        crc     <= 8'd0;
        in_cnt  <= 8'd0;
        out_cnt <= 8'd0;
        ovf     <= 1'b0;
      end else begin
        if (take)
          in_cnt <= in_cnt + 8'd1;
        if (drop)
          ovf <= 1'b1;
        if ((state == LEN) && beat)
          crc <= crc8(crc, n_len);
        if (pop) begin
          crc     <= crc8(crc, head);
          out_cnt <= out_cnt + 8'd1;
        end
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_frame_done = done_q;
  assign o_overflow   = ovf;

endmodule
